rpc_tx_sequencer: RTL

RPC_TX_SEQUENCER -- requirements
Module: rpc_tx_sequencer

---
 rtl/rpc_pkg.sv | 66 ++++++
 rtl/rpc_tx_sequencer_if.sv | 48 ++++
 rtl/rpc_tx_timer.sv | 34 +++
 rtl/rpc_tx_sequencer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/rpc_pkg.sv
// Shared types for the RPC transmit sequencer: FSM states, latched config,
// the registered pad-output bundle and the timer reload helper.
package rpc_pkg;

    localparam int RPC_CMD_W = 32;
    localparam int RPC_DB_W  = 16;
    localparam int RPC_LEN_W = 8;
    localparam int RPC_TMR_W = 9;

    typedef enum logic [3:0] {
        IDLE,
        CMD0,
        CMD1,
        WLAT,
        WPRE,
        WDATA,
        WPOST,
        RDATA,
        GAP
    } rpc_state_e;

    typedef struct packed {
        logic [3:0] wl;
        logic [3:0] rl;
        logic [3:0] gap;
    } rpc_cfg_t;

    typedef struct packed {
        logic                clk;
        logic                clkn;
        logic                csn;
        logic                stb;
        logic [RPC_DB_W-1:0] db;
        logic                dqs;
        logic                dqsn;
        logic                oe_db;
        logic                oe_dqs;
        logic                ie_db;
        logic                ie_dqs;
        logic                pd_en_db;
        logic                pd_en_dqs;
    } rpc_pad_t;

    localparam rpc_pad_t RPC_PAD_RST = '{
        clk: 1'b0, clkn: 1'b1, csn: 1'b1, stb: 1'b0, db: '0,
        dqs: 1'b0, dqsn: 1'b1, oe_db: 1'b0, oe_dqs: 1'b0,
        ie_db: 1'b0, ie_dqs: 1'b0, pd_en_db: 1'b1, pd_en_dqs: 1'b1
    };

    // Timer reload value on entry to a timed state; the timer counts down to
    // zero, so each value is the state's cycle count minus one.
    function automatic logic [RPC_TMR_W-1:0] rpc_tmr_load(rpc_state_e st, rpc_cfg_t cfg,
                                                          logic [RPC_LEN_W-1:0] len);
        logic [RPC_TMR_W-1:0] v;
        v = '0;
        case (st)
            WLAT:    v = RPC_TMR_W'(cfg.wl) - RPC_TMR_W'(1);
            WDATA:   v = RPC_TMR_W'(len);
            RDATA:   v = RPC_TMR_W'(cfg.rl) + RPC_TMR_W'(len) + RPC_TMR_W'(2);
            GAP:     v = (cfg.gap == '0) ? '0 : RPC_TMR_W'(cfg.gap) - RPC_TMR_W'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rpc_tx_sequencer_if.sv
// Host command/write-data/status signals plus the RPC pad-side outputs.
interface rpc_tx_sequencer_if;

    logic                          cmd_valid_i;
    logic                          cmd_ready_o;
    logic [rpc_pkg::RPC_CMD_W-1:0] cmd_i;
    logic                          cmd_write_i;
    logic [rpc_pkg::RPC_LEN_W-1:0] cmd_len_i;
    logic                          wdata_valid_i;
    logic                          wdata_ready_o;
    logic [rpc_pkg::RPC_DB_W-1:0]  wdata_i;
    logic [3:0]                    cfg_wl_i;
    logic [3:0]                    cfg_rl_i;
    logic [3:0]                    cfg_gap_i;
    logic                          busy_o;
    logic                          done_o;
    logic                          underrun_o;
    logic                          out_clk_o;
    logic                          out_clkn_o;
    logic                          out_csn_o;
    logic                          out_stb_o;
    logic [rpc_pkg::RPC_DB_W-1:0]  out_db_o;
    logic                          out_dqs_o;
    logic                          out_dqsn_o;
    logic                          oe_db_o;
    logic                          oe_dqs_o;
    logic                          ie_db_o;
    logic                          ie_dqs_o;
    logic                          pd_en_db_o;
    logic                          pd_en_dqs_o;

    modport master (
        output cmd_valid_i, cmd_i, cmd_write_i, cmd_len_i, wdata_valid_i, wdata_i,
               cfg_wl_i, cfg_rl_i, cfg_gap_i,
        input  cmd_ready_o, wdata_ready_o, busy_o, done_o, underrun_o,
               out_clk_o, out_clkn_o, out_csn_o, out_stb_o, out_db_o, out_dqs_o, out_dqsn_o,
               oe_db_o, oe_dqs_o, ie_db_o, ie_dqs_o, pd_en_db_o, pd_en_dqs_o
    );

    modport slave (
        input  cmd_valid_i, cmd_i, cmd_write_i, cmd_len_i, wdata_valid_i, wdata_i,
               cfg_wl_i, cfg_rl_i, cfg_gap_i,
        output cmd_ready_o, wdata_ready_o, busy_o, done_o, underrun_o,
               out_clk_o, out_clkn_o, out_csn_o, out_stb_o, out_db_o, out_dqs_o, out_dqsn_o,
               oe_db_o, oe_dqs_o, ie_db_o, ie_dqs_o, pd_en_db_o, pd_en_dqs_o
    );

endinterface

// File: rtl/rpc_tx_timer.sv
// Loadable down-counter with a zero flag, shared by every timed FSM state.
module rpc_tx_timer
    import rpc_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [RPC_TMR_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [RPC_TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - RPC_TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rpc_tx_sequencer.sv
// RPC transmit sequencer: command phase, write/read data phases and CSn gap.
// Pad outputs are computed from the next state and registered.
module rpc_tx_sequencer
    import rpc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    rpc_tx_sequencer_if.slave bus
);

    rpc_state_e           state_q, state_d;
    logic [RPC_DB_W-1:0]  cmd_lo_q, cmd_lo_d;
    logic                 write_q, write_d;
    logic [RPC_LEN_W-1:0] len_q, len_d;
    rpc_cfg_t             cfg_q, cfg_d;
    rpc_pad_t             pad_q, pad_d;

    logic                 cmd_ready;
    logic                 cmd_accept;
    logic                 wd_ready;
    logic                 wd_fire;
    logic                 tmr_load;
    logic                 tmr_dec;
    logic                 tmr_zero;
    logic [RPC_TMR_W-1:0] tmr_val;

    // Handshakes are masked by reset so an aborted burst consumes nothing.
    assign cmd_ready  = (state_q == IDLE) && !rst_i;
    assign cmd_accept = cmd_ready && bus.cmd_valid_i;
    assign wd_ready   = (state_q == WDATA) && !rst_i;
    assign wd_fire    = wd_ready && bus.wdata_valid_i;

    always_comb begin
        state_d  = state_q;
        cmd_lo_d = cmd_lo_q;
        write_d  = write_q;
        len_d    = len_q;
        cfg_d    = cfg_q;
        tmr_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    state_d  = CMD0;
                    cmd_lo_d = bus.cmd_i[RPC_DB_W-1:0];
                    write_d  = bus.cmd_write_i;
                    len_d    = bus.cmd_len_i;
                    cfg_d    = '{wl: bus.cfg_wl_i, rl: bus.cfg_rl_i, gap: bus.cfg_gap_i};
                end
            end
            CMD0: state_d = CMD1;
            CMD1: begin
                if (!write_q)             state_d = RDATA;
                else if (cfg_q.wl != '0)  state_d = WLAT;
                else                      state_d = WPRE;
            end
            WLAT: begin
                if (tmr_zero) state_d = WPRE;
                else          tmr_dec = 1'b1;
            end
            WPRE: state_d = WDATA;
            WDATA: begin
                if (wd_fire) begin
                    if (tmr_zero) state_d = WPOST;
                    else          tmr_dec = 1'b1;
                end
            end
            WPOST: state_d = GAP;
            RDATA: begin
                if (tmr_zero) state_d = GAP;
                else          tmr_dec = 1'b1;
            end
            GAP: begin
                if (tmr_zero) state_d = IDLE;
                else          tmr_dec = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tmr_load = (state_d != state_q) && (state_d inside {WLAT, WDATA, RDATA, GAP});
    assign tmr_val  = rpc_tmr_load(state_d, cfg_q, len_q);

    always_comb begin
        pad_d        = pad_q;
        pad_d.clk    = (state_d != IDLE) ? ~pad_q.clk : 1'b0;
        pad_d.csn    = !(state_d inside {CMD0, CMD1, WLAT, WPRE, WDATA, WPOST, RDATA});
        pad_d.stb    = state_d inside {CMD0, CMD1};
        pad_d.oe_db  = state_d inside {CMD0, CMD1, WLAT, WPRE, WDATA, WPOST};
        pad_d.oe_dqs = state_d inside {WPRE, WDATA, WPOST};
        pad_d.ie_db  = (state_d == RDATA);
        pad_d.ie_dqs = (state_d == RDATA);

        if (state_d == IDLE)       pad_d.db = '0;
        else if (cmd_accept)       pad_d.db = bus.cmd_i[RPC_CMD_W-1:RPC_DB_W];
        else if (state_d == CMD1)  pad_d.db = cmd_lo_q;
        else if (wd_fire)          pad_d.db = bus.wdata_i;

        // Preamble parks DQS low so the first data word launches a rising strobe.
        if (state_d inside {IDLE, WPRE}) pad_d.dqs = 1'b0;
        else if (wd_fire)                pad_d.dqs = ~pad_q.dqs;

        pad_d.clkn      = ~pad_d.clk;
        pad_d.dqsn      = ~pad_d.dqs;
        pad_d.pd_en_db  = ~pad_d.oe_db;
        pad_d.pd_en_dqs = ~pad_d.oe_dqs;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cmd_lo_q <= '0;
            write_q  <= 1'b0;
            len_q    <= '0;
            cfg_q    <= '0;
            pad_q    <= RPC_PAD_RST;
        end else begin
            state_q  <= state_d;
            cmd_lo_q <= cmd_lo_d;
            write_q  <= write_d;
            len_q    <= len_d;
            cfg_q    <= cfg_d;
            pad_q    <= pad_d;
        end
    end

    rpc_tx_timer u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    assign bus.cmd_ready_o   = cmd_ready;
    assign bus.wdata_ready_o = wd_ready;
    assign bus.busy_o        = (state_q != IDLE) && !rst_i;
    assign bus.done_o        = (state_q == GAP) && tmr_zero && !rst_i;
    assign bus.underrun_o    = (state_q == WDATA) && !bus.wdata_valid_i && !rst_i;

    assign bus.out_clk_o   = pad_q.clk;
    assign bus.out_clkn_o  = pad_q.clkn;
    assign bus.out_csn_o   = pad_q.csn;
    assign bus.out_stb_o   = pad_q.stb;
    assign bus.out_db_o    = pad_q.db;
    assign bus.out_dqs_o   = pad_q.dqs;
    assign bus.out_dqsn_o  = pad_q.dqsn;
    assign bus.oe_db_o     = pad_q.oe_db;
    assign bus.oe_dqs_o    = pad_q.oe_dqs;
    assign bus.ie_db_o     = pad_q.ie_db;
    assign bus.ie_dqs_o    = pad_q.ie_dqs;
    assign bus.pd_en_db_o  = pad_q.pd_en_db;
    assign bus.pd_en_dqs_o = pad_q.pd_en_dqs;

endmodule
